// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder
// Left-edge feeder for the systolic array. Accepts one LANES-wide operand
// vector per cycle, delays lane r by r+1 cycles to form the diagonal
// wavefront, and keeps shifting zeros in for LANES cycles after the last
// vector so that vector fully enters the array. A programmed vector count
// ends the transfer, and a one-cycle done pulse marks its completion.
module sa_skew_feeder #(
   parameter int LANES = 3,
   parameter int DW    = 64,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      vec_count,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DW*LANES-1:0]   in_data,
   output logic [DW*LANES-1:0]   out_data,
   output logic [LANES-1:0]      out_lane_valid,
   output logic                  busy,
   output logic                  done
);

   // The drain counter runs 0..LANES-1. The width is forced to at least one
   // bit so a single-lane build still has a legal counter.
   localparam int DRN_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  k_reg, k_next;
   logic [CNT_W-1:0]  acc_cnt_reg, acc_cnt_next;
   logic [DRN_W-1:0]  drain_reg, drain_next;
   logic              accept;

   // Control state: FSM state, latched vector count, accepted count, drain count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= IDLE;
         k_reg       <= '0;
         acc_cnt_reg <= '0;
         drain_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         k_reg       <= k_next;
         acc_cnt_reg <= acc_cnt_next;
         drain_reg   <= drain_next;
      end
   end

   // Next-state logic and handshake outputs. The accept that brings the count
   // up to K moves straight to FLUSH; FLUSH then lasts exactly LANES cycles,
   // which is the depth of the longest lane chain.
   always_comb begin
      state_next   = state_reg;
      k_next       = k_reg;
      acc_cnt_next = acc_cnt_reg;
      drain_next   = drain_reg;
      in_ready     = 1'b0;
      accept       = 1'b0;
      done         = 1'b0;
      busy         = (state_reg != IDLE);

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (vec_count != '0) begin
                  k_next       = vec_count;
                  acc_cnt_next = '0;
                  state_next   = STREAM;
               end else begin
                  // An empty transfer still reports completion.
                  state_next = DONE;
               end
            end
         end

         STREAM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept       = 1'b1;
               acc_cnt_next = acc_cnt_reg + 1'b1;
               if (acc_cnt_next == k_reg) begin
                  drain_next = '0;
                  state_next = FLUSH;
               end
            end
         end

         FLUSH: begin
            if (drain_reg == DRAIN_LAST) begin
               state_next = DONE;
            end else begin
               drain_next = drain_reg + 1'b1;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One delay chain per lane; lane gi is gi+1 stages deep. The chains shift
   // unconditionally, so a bubble or the flush simply pushes a zero word with
   // a cleared valid bit and the relative skew of older vectors is kept.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [DW-1:0] word_reg [0:gi];
         logic          vld_reg  [0:gi];

         // Shift the lane chain; the head takes the new word only on an accept.
         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int s = 0; s <= gi; s++) begin
                  word_reg[s] <= '0;
                  vld_reg[s]  <= 1'b0;
               end
            end else begin
               word_reg[0] <= accept ? in_data[DW*gi +: DW] : '0;
               vld_reg[0]  <= accept;
               for (int s = 1; s <= gi; s++) begin
                  word_reg[s] <= word_reg[s-1];
                  vld_reg[s]  <= vld_reg[s-1];
               end
            end
         end

         assign out_data[DW*gi +: DW] = word_reg[gi];
         assign out_lane_valid[gi]    = vld_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder
// Directed stimulus for sa_skew_feeder. Each accepted vector pushes its
// per-lane expected words (with the cycle they must appear) into lane
// queues, and each transfer pushes its expected done cycle. A monitor on the
// falling edge compares the DUT outputs against the queue heads every cycle.
module tb_sa_skew_feeder;

   localparam int LANES = 3;
   localparam int DW    = 64;
   localparam int CNT_W = 16;
   localparam int BW    = DW * LANES;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [CNT_W-1:0]  vec_count;
   logic              in_valid;
   logic              in_ready;
   logic [BW-1:0]     in_data;
   logic [BW-1:0]     out_data;
   logic [LANES-1:0]  out_lane_valid;
   logic              busy;
   logic              done;

   typedef struct {
      int            cyc;
      logic [DW-1:0] word;
   } exp_t;

   exp_t lane_q [LANES][$];
   int   done_q [$];

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   logic [BW-1:0] v_a, v_b, v_c, v_d, v_e;

   sa_skew_feeder #(
      .LANES (LANES),
      .DW    (DW),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .vec_count      (vec_count),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_data       (out_data),
      .out_lane_valid (out_lane_valid),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // Cycle number: cycle c is the period that begins at the c-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vector accepted in cycle t: lane r must show its word in cycle t+r+1.
   task automatic push_vec(input int t, input logic [BW-1:0] v);
      exp_t e;
      for (int r = 0; r < LANES; r++) begin
         e.cyc  = t + r + 1;
         e.word = v[DW*r +: DW];
         lane_q[r].push_back(e);
      end
   endtask

   function automatic logic [BW-1:0] vec3(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                          input logic [DW-1:0] l2);
      return {l2, l1, l0};
   endfunction

   // Monitor: every cycle, each lane must carry exactly the expected word
   // (or a zero bubble), and done must pulse exactly when expected.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int r = 0; r < LANES; r++) begin
            bit   exp_now;
            exp_t e;
            exp_now = (lane_q[r].size() > 0) && (lane_q[r][0].cyc == cyc);
            check($sformatf("lane%0d_valid", r), {255'd0, out_lane_valid[r]}, {255'd0, exp_now});
            if (exp_now) begin
               e = lane_q[r].pop_front();
               check($sformatf("lane%0d_word", r), {192'd0, out_data[DW*r +: DW]}, {192'd0, e.word});
            end else begin
               check($sformatf("lane%0d_bubble", r), {192'd0, out_data[DW*r +: DW]}, 256'd0);
            end
         end
         begin
            bit done_now;
            done_now = (done_q.size() > 0) && (done_q[0] == cyc);
            check("done", {255'd0, done}, {255'd0, done_now});
            if (done_now) begin
               void'(done_q.pop_front());
               check("busy_at_done", {255'd0, busy}, 256'd1);
            end
         end
      end
   end

   initial begin
      int s;

      v_a = vec3(64'd1, 64'd2, 64'd3);
      v_b = vec3(64'd4, 64'd5, 64'd6);
      v_c = vec3(64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
      v_d = vec3(64'h0000_0000_0000_00A5, 64'h5A5A_5A5A_5A5A_5A5A, 64'hC3C3_0000_3C3C_FFFF);
      v_e = vec3(64'h1111_2222_3333_4444, 64'h0, 64'h7777_8888_9999_AAAA);

      // Test 1: reset held low for two edges with random inputs.
      reset     = 1'b0;
      start     = 1'($urandom);
      vec_count = CNT_W'($urandom);
      in_valid  = 1'($urandom);
      for (int i = 0; i < BW / 32; i++) in_data[32*i +: 32] = $urandom;
      tick();
      start     = 1'($urandom);
      vec_count = CNT_W'($urandom);
      in_valid  = 1'($urandom);
      for (int i = 0; i < BW / 32; i++) in_data[32*i +: 32] = $urandom;
      tick();
      reset     = 1'b1;
      start     = 1'b0;
      vec_count = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      check("rst_out_data", {64'd0, out_data}, 256'd0);
      check("rst_lane_valid", {253'd0, out_lane_valid}, 256'd0);
      check("rst_in_ready", {255'd0, in_ready}, 256'd0);
      check("rst_busy", {255'd0, busy}, 256'd0);
      check("rst_done", {255'd0, done}, 256'd0);
      mon_en = 1'b1;

      // Test 2: K=2, back-to-back accepts.
      tick(); s = cyc; start = 1'b1; vec_count = 16'd2;
      tick(); start = 1'b0; in_valid = 1'b1; in_data = v_a;
      check("t2_ready_a", {255'd0, in_ready}, 256'd1);
      push_vec(cyc, v_a);
      tick(); in_data = v_b;
      check("t2_ready_b", {255'd0, in_ready}, 256'd1);
      push_vec(cyc, v_b);
      done_q.push_back(s + 6);
      tick(); in_valid = 1'b0; in_data = '0;
      check("t2_ready_flush", {255'd0, in_ready}, 256'd0);
      check("t2_busy_flush", {255'd0, busy}, 256'd1);
      repeat (6) tick();
      check("t2_idle", {255'd0, busy}, 256'd0);

      // Test 3: K=2 with a one-cycle bubble between the vectors.
      tick(); s = cyc; start = 1'b1; vec_count = 16'd2;
      tick(); start = 1'b0; in_valid = 1'b1; in_data = v_c;
      push_vec(cyc, v_c);
      tick(); in_valid = 1'b0; in_data = v_d;
      check("t3_ready_bubble", {255'd0, in_ready}, 256'd1);
      tick(); in_valid = 1'b1; in_data = v_d;
      push_vec(cyc, v_d);
      done_q.push_back(s + 7);
      tick(); in_valid = 1'b0; in_data = '0;
      repeat (6) tick();
      check("t3_idle", {255'd0, busy}, 256'd0);

      // Test 4: empty transfer; in_valid held high must never be captured.
      tick(); s = cyc; start = 1'b1; vec_count = 16'd0; in_valid = 1'b1; in_data = v_a;
      tick(); start = 1'b0;
      done_q.push_back(s + 1);
      check("t4_busy", {255'd0, busy}, 256'd1);
      check("t4_in_ready", {255'd0, in_ready}, 256'd0);
      tick();
      check("t4_idle", {255'd0, busy}, 256'd0);
      check("t4_in_ready_idle", {255'd0, in_ready}, 256'd0);
      tick(); in_valid = 1'b0; in_data = '0;
      repeat (3) tick();

      // Test 5: reset one cycle after the first accept of a K=4 transfer.
      tick(); s = cyc; start = 1'b1; vec_count = 16'd4;
      tick(); start = 1'b0; in_valid = 1'b1; in_data = v_e;
      // Only lane 0 escapes before the reset edge clears the chains.
      lane_q[0].push_back('{cyc: s + 2, word: v_e[DW-1:0]});
      tick(); reset = 1'b0; in_data = v_b;
      tick(); reset = 1'b1; in_valid = 1'b0; in_data = '0;
      check("t5_out_data", {64'd0, out_data}, 256'd0);
      check("t5_lane_valid", {253'd0, out_lane_valid}, 256'd0);
      check("t5_in_ready", {255'd0, in_ready}, 256'd0);
      check("t5_busy", {255'd0, busy}, 256'd0);
      check("t5_done", {255'd0, done}, 256'd0);
      start = 1'b1; vec_count = 16'd1;
      tick(); start = 1'b0; in_valid = 1'b1; in_data = v_b;
      push_vec(cyc, v_b);
      done_q.push_back(cyc + 4);
      tick(); in_valid = 1'b0; in_data = '0;
      repeat (6) tick();
      check("t5_idle", {255'd0, busy}, 256'd0);

      // Test 6: start toggled during STREAM/FLUSH, in_valid during FLUSH/IDLE.
      tick(); s = cyc; start = 1'b1; vec_count = 16'd3;
      tick(); vec_count = 16'd1; in_valid = 1'b1; in_data = v_d;
      push_vec(cyc, v_d);
      tick(); vec_count = 16'd7; in_valid = 1'b0;
      tick(); in_valid = 1'b1; in_data = v_a;
      push_vec(cyc, v_a);
      tick(); in_data = v_c;
      push_vec(cyc, v_c);
      done_q.push_back(s + 8);
      tick(); vec_count = 16'd2; in_data = v_e;
      check("t6_ready_flush0", {255'd0, in_ready}, 256'd0);
      tick();
      check("t6_ready_flush1", {255'd0, in_ready}, 256'd0);
      tick();
      check("t6_ready_flush2", {255'd0, in_ready}, 256'd0);
      tick(); start = 1'b0; in_valid = 1'b0;
      tick();
      check("t6_idle", {255'd0, busy}, 256'd0);
      in_valid = 1'b1; in_data = v_b;
      repeat (5) tick();
      check("t6_idle_no_capture", {255'd0, busy}, 256'd0);
      in_valid = 1'b0; in_data = '0;
      repeat (4) tick();

      for (int r = 0; r < LANES; r++) begin
         check($sformatf("lane%0d_queue_empty", r), 256'(lane_q[r].size()), 256'd0);
      end
      check("done_queue_empty", 256'(done_q.size()), 256'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
